// File: rtl/fir_pipe.sv
// Pipelined FIR filter: delay line, product, partial-sum and round/saturate stages; FIR_PIPE_ROUND_EN selects round-half-up.
// Latency: sample in cycle n gives fir_valid in cycle n+4; no backpressure, every offered sample is accepted.
module fir_pipe #(
   parameter int TAPS = 32,
   parameter int DW   = 16,
   parameter int CW   = 20
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        data_valid,
   input  logic signed [DW-1:0]        data,
   input  logic                        flush,
   input  logic                        coef_we,
   input  logic [$clog2(TAPS)-1:0]     coef_addr,
   input  logic signed [CW-1:0]        coef_wdata,
   output logic                        fir_valid,
   output logic signed [DW-1:0]        fir_d
);

   localparam int AW     = $clog2(TAPS);
   localparam int PW     = DW + CW;
   localparam int GROUPS = TAPS / 8;
   localparam int PSW    = PW + 3;
   localparam int SW     = DW + CW + $clog2(TAPS);
   localparam logic signed [SW:0] SAT_HI = {{(SW-DW+2){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW:0] SAT_LO = {{(SW-DW+2){1'b1}}, {(DW-1){1'b0}}};

   logic signed [DW-1:0]  tap    [TAPS];
   logic signed [CW-1:0]  coef   [TAPS];
   logic signed [PW-1:0]  prod   [TAPS];
   logic signed [PSW-1:0] psum   [GROUPS];
   logic signed [PSW-1:0] psum_c [GROUPS];
   logic signed [SW:0]    acc_c;
   logic signed [SW:0]    scaled_c;
   logic signed [DW-1:0]  sat_c;
   logic                  addr_ok;
   logic                  wr_pend;
   logic [AW-1:0]         wr_addr;
   logic signed [CW-1:0]  wr_data;
   logic [6:0]            warm_cnt;
   logic                  tag0, tag1, tag2;

   generate
      if (TAPS == (1 << AW)) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_part
         assign addr_ok = (coef_addr < AW'(TAPS));
      end
   endgenerate

   // Writes land one edge late so a sample taken alongside a write still multiplies the old value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_pend <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      end else begin
         wr_pend <= coef_we && addr_ok;
         wr_addr <= coef_addr;
         wr_data <= coef_wdata;
         if (wr_pend) coef[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         warm_cnt <= '0;
         tag0     <= 1'b0;
         for (int k = 0; k < TAPS; k++) tap[k] <= '0;
      end else if (flush) begin
         warm_cnt <= '0;
         tag0     <= 1'b0;
         for (int k = 0; k < TAPS; k++) tap[k] <= '0;
      end else if (data_valid) begin
         tap[0] <= data;
         for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
         if (warm_cnt < 7'(TAPS)) warm_cnt <= warm_cnt + 7'd1;
         tag0 <= (warm_cnt >= 7'(TAPS - 1));
      end else begin
         tag0 <= 1'b0;
      end
   end

   always_comb begin
      for (int g = 0; g < GROUPS; g++) begin
         psum_c[g] = '0;
         for (int j = 0; j < 8; j++) psum_c[g] = psum_c[g] + PSW'(prod[g*8 + j]);
      end
   end

   always_comb begin
      acc_c = '0;
      for (int g = 0; g < GROUPS; g++) acc_c = acc_c + (SW+1)'(psum[g]);
`ifdef FIR_PIPE_ROUND_EN
      acc_c = acc_c + (SW+1)'(1 << 15);
`endif
      scaled_c = acc_c >>> 16;
      if (scaled_c > SAT_HI)      sat_c = {1'b0, {(DW-1){1'b1}}};
      else if (scaled_c < SAT_LO) sat_c = {1'b1, {(DW-1){1'b0}}};
      else                        sat_c = scaled_c[DW-1:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tag1      <= 1'b0;
         tag2      <= 1'b0;
         fir_valid <= 1'b0;
         fir_d     <= '0;
         for (int k = 0; k < TAPS; k++)   prod[k] <= '0;
         for (int g = 0; g < GROUPS; g++) psum[g] <= '0;
      end else begin
         for (int k = 0; k < TAPS; k++)   prod[k] <= PW'(tap[k]) * PW'(coef[k]);
         for (int g = 0; g < GROUPS; g++) psum[g] <= psum_c[g];
         tag1      <= tag0 && !flush;
         tag2      <= tag1 && !flush;
         fir_valid <= tag2 && !flush;
         fir_d     <= (tag2 && !flush) ? sat_c : '0;
      end
   end

endmodule

// File: tb/tb_fir_pipe.sv
// Scoreboard bench for fir_pipe: a reference model queues expected outputs as samples are driven.
module tb_fir_pipe;
   localparam int TAPS = 32;
   localparam int DW   = 16;
   localparam int CW   = 20;
   localparam int AW   = $clog2(TAPS);

   logic                 CLK = 1'b0;
   logic                 RST_N = 1'b0;
   logic                 data_valid = 1'b0;
   logic signed [DW-1:0] data = '0;
   logic                 flush = 1'b0;
   logic                 coef_we = 1'b0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [CW-1:0] coef_wdata = '0;
   logic                 fir_valid;
   logic signed [DW-1:0] fir_d;

   fir_pipe #(.TAPS(TAPS), .DW(DW), .CW(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .data_valid(data_valid), .data(data), .flush(flush),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .fir_valid(fir_valid), .fir_d(fir_d)
   );

   always #5 CLK = ~CLK;

   typedef struct { int cyc; logic [DW-1:0] d; } exp_t;
   exp_t sb[$];
   exp_t e;
   int   mtap [TAPS];
   int   mcoef [TAPS];
   int   mcnt = 0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   vcount = 0;
   logic [DW-1:0] last_d = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [DW-1:0] model_out();
      longint acc = 0;
      for (int k = 0; k < TAPS; k++) acc += longint'(mtap[k]) * longint'(mcoef[k]);
`ifdef FIR_PIPE_ROUND_EN
      acc += 32768;
`endif
      acc = acc >>> 16;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return acc[DW-1:0];
   endfunction

   // Output monitor: pops the scoreboard when a result is due.
   always @(negedge CLK) begin
      if (fir_valid === 1'b1) begin
         vcount++;
         last_d = fir_d;
         checks++;
         if (sb.size() == 0 || sb[0].cyc != cyc) begin
            errors++;
            $display("FAIL unexpected_valid cyc=%0d fir_d=%h queued=%0d", cyc, fir_d, sb.size());
         end else begin
            e = sb.pop_front();
            if (fir_d !== e.d) begin
               errors++;
               $display("FAIL fir_d cyc=%0d got=%h exp=%h", cyc, fir_d, e.d);
            end
         end
      end else begin
         checks++;
         if (fir_d !== '0) begin
            errors++;
            $display("FAIL idle_fir_d cyc=%0d got=%h exp=0000", cyc, fir_d);
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_valid cyc=%0d got=%b exp=1 (fir_d exp %h)", cyc, fir_valid, e.d);
         end
      end
   end

   task automatic step(input logic dv, input logic [DW-1:0] d, input logic fl,
                       input logic we, input logic [AW-1:0] a, input logic [CW-1:0] wd);
      exp_t x;
      data_valid = dv; data = d; flush = fl;
      coef_we = we; coef_addr = a; coef_wdata = wd;
      if (fl) begin
         for (int k = 0; k < TAPS; k++) mtap[k] = 0;
         mcnt = 0;
         while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      end else if (dv) begin
         for (int k = TAPS-1; k > 0; k--) mtap[k] = mtap[k-1];
         mtap[0] = int'($signed(d));
         if (mcnt >= TAPS-1) begin
            x.cyc = cyc + 4;
            x.d   = model_out();
            sb.push_back(x);
         end
         if (mcnt < TAPS) mcnt++;
      end
      if (we && int'(a) < TAPS) mcoef[a] = int'($signed(wd));
      @(posedge CLK); #1;
      data_valid = 1'b0; flush = 1'b0; coef_we = 1'b0;
   endtask

   task automatic sample(input logic [DW-1:0] d);
      step(1'b1, d, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic wcoef(input int a, input logic [CW-1:0] wd);
      step(1'b0, '0, 1'b0, 1'b1, AW'(a), wd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic model_reset();
      for (int k = 0; k < TAPS; k++) begin mtap[k] = 0; mcoef[k] = 0; end
      mcnt = 0;
      sb.delete();
   endtask

   task automatic test_reset();
      model_reset();
      RST_N = 1'b0;
      #23;
      checks++;
      if (fir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fir_valid); end
      checks++;
      if (fir_d !== '0) begin errors++; $display("FAIL reset_fir_d got=%h exp=0000", fir_d); end
      @(posedge CLK); #1;
      RST_N = 1'b1;
   endtask

   task automatic test_warmup_latency();
      wcoef(0, 20'h10000);
      for (int i = 0; i < TAPS-1; i++) sample(16'h0100);
      idle(4);
      checks++;
      if (vcount !== 0) begin errors++; $display("FAIL warmup_pulses got=%0d exp=0", vcount); end
      sample(16'h0100);
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (fir_valid !== 1'b0) begin errors++; $display("FAIL latency_early n+%0d got=%b exp=0", i, fir_valid); end
         idle(1);
      end
      checks++;
      if (fir_valid !== 1'b1 || fir_d !== 16'sh0100)
         begin errors++; $display("FAIL latency_n4 got=%b/%h exp=1/0100", fir_valid, fir_d); end
      for (int i = 0; i < 8; i++) sample(16'h0100 + 16'(i * 16'h0111));
      idle(5);
   endtask

   task automatic test_saturation();
      for (int k = 0; k < TAPS; k++) wcoef(k, 20'h10000);
      for (int i = 0; i < TAPS; i++) sample(16'h7FFF);
      idle(5);
      checks++;
      if (last_d !== 16'h7FFF) begin errors++; $display("FAIL sat_hi got=%h exp=7fff", last_d); end
      for (int i = 0; i < TAPS; i++) sample(16'h8000);
      idle(5);
      checks++;
      if (last_d !== 16'h8000) begin errors++; $display("FAIL sat_lo got=%h exp=8000", last_d); end
   endtask

   task automatic test_rounding();
      logic [DW-1:0] exp_pos, exp_neg;
`ifdef FIR_PIPE_ROUND_EN
      exp_pos = 16'h0001; exp_neg = 16'h0000;
`else
      exp_pos = 16'h0000; exp_neg = 16'hFFFF;
`endif
      for (int k = 1; k < TAPS; k++) wcoef(k, 20'h00000);
      wcoef(0, 20'h08000);
      sample(16'h0001);
      idle(5);
      checks++;
      if (last_d !== exp_pos) begin errors++; $display("FAIL round_pos got=%h exp=%h", last_d, exp_pos); end
      sample(16'hFFFF);
      idle(5);
      checks++;
      if (last_d !== exp_neg) begin errors++; $display("FAIL round_neg got=%h exp=%h", last_d, exp_neg); end
   endtask

   task automatic test_coef_same_cycle();
      step(1'b1, 16'h0100, 1'b0, 1'b1, '0, 20'h10000);
      idle(5);
      checks++;
      if (last_d !== 16'h0080) begin errors++; $display("FAIL coef_old got=%h exp=0080", last_d); end
      sample(16'h0100);
      idle(5);
      checks++;
      if (last_d !== 16'h0100) begin errors++; $display("FAIL coef_new got=%h exp=0100", last_d); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < TAPS; k++) wcoef(k, CW'($urandom_range(0, 32767)) - 20'sd16384);
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'b0,
              1'($urandom_range(0, 7) == 0), AW'($urandom_range(0, TAPS-1)),
              CW'($urandom_range(0, 32767)) - 20'sd16384);
      for (int i = 0; i < 10; i++) sample(DW'($urandom));
      idle(5);
   endtask

   task automatic test_flush();
      int vc0;
      for (int i = 0; i < 40; i++) sample(DW'(i * 37));
      step(1'b1, 16'h1234, 1'b1, 1'b1, AW'(1), 20'h00100);
      vc0 = vcount;
      for (int i = 0; i < TAPS-1; i++) sample(DW'(i * 53));
      idle(4);
      checks++;
      if (vcount !== vc0) begin errors++; $display("FAIL flush_quiet got=%0d exp=%0d", vcount, vc0); end
      sample(16'h0200);
      idle(5);
      checks++;
      if (vcount !== vc0 + 1) begin errors++; $display("FAIL flush_resume got=%0d exp=%0d", vcount, vc0 + 1); end
   endtask

   task automatic test_reset_midstream();
      int vc0;
      for (int i = 0; i < 6; i++) sample(DW'(16'h0100 + i));
      checks++;
      if (fir_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", fir_valid); end
      #2 RST_N = 1'b0;
      model_reset();
      #1;
      checks++;
      if (fir_valid !== 1'b0 || fir_d !== '0)
         begin errors++; $display("FAIL async_reset got=%b/%h exp=0/0000", fir_valid, fir_d); end
      @(posedge CLK); #3;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      vc0 = vcount;
      idle(6);
      checks++;
      if (vcount !== vc0) begin errors++; $display("FAIL late_valid got=%0d exp=%0d", vcount, vc0); end
      for (int i = 0; i < TAPS; i++) sample(16'h0100);
      idle(5);
      checks++;
      if (vcount !== vc0 + 1 || last_d !== '0)
         begin errors++; $display("FAIL zero_coef got=%0d/%h exp=%0d/0000", vcount, last_d, vc0 + 1); end
   endtask

   initial begin
      test_reset();
      test_warmup_latency();
      test_saturation();
      test_rounding();
      test_coef_same_cycle();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL drained got=%0d exp=0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fir_pipe.md
FIR_PIPE -- requirements
Module: fir_pipe

Interface
REQ-001 Parameter TAPS, default 32, number of filter taps (multiple of 8, 8..64).
REQ-002 Parameter DW, default 16, sample and output width, signed Q(DW-8).8.
REQ-003 Parameter CW, default 20, coefficient width, signed, 16 fractional bits.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 data_valid  input  1  a sample is offered this cycle; always accepted.
REQ-007 data  input  DW  signed input sample.
REQ-008 flush  input  1  synchronous clear of delay line, warm-up count and in-flight results.
REQ-009 coef_we  input  1  coefficient write strobe.
REQ-010 coef_addr  input  ceil(log2(TAPS))  coefficient index; 0 multiplies the newest sample.
REQ-011 coef_wdata  input  CW  signed coefficient value.
REQ-012 fir_valid  output  1  fir_d holds a valid result this cycle.
REQ-013 fir_d  output  DW  signed filter output.

Function
REQ-014 Delay line: on data_valid, tap[0] <= data and tap[k] <= tap[k-1] for 1..TAPS-1; otherwise it holds.
REQ-015 Coefficient RAM: TAPS registers of CW bits; coef_we writes coef_wdata to coef_addr at the clock edge.
REQ-016 Writes to out-of-range coef_addr (>= TAPS) are ignored.
REQ-017 A coefficient written in the same cycle as data_valid takes effect for the next sample; the current sample uses the old value.
REQ-018 Pipeline: P1 registers TAPS full-precision products; P2 registers TAPS/8 partial sums; P3 registers the final sum after rounding and saturation into fir_d.
REQ-019 Latency: sample accepted in cycle n gives fir_valid=1 in cycle n+4; one result per accepted sample; back-to-back data_valid gives a result every cycle.
REQ-020 Accumulator width is DW+CW+ceil(log2(TAPS)); no intermediate overflow is permitted.
REQ-021 Result scaling: drop 16 fractional LSBs so output keeps 8 fractional bits.
REQ-022 Saturation: results above 2^(DW-1)-1 clamp to 0x7FFF and results below -2^(DW-1) clamp to 0x8000 (DW=16).
REQ-023 Warm-up: a 7-bit counter counts accepted samples up to TAPS and then holds; results for the first TAPS-1 samples after reset or flush are suppressed (fir_valid=0).
REQ-024 fir_d = 0 whenever fir_valid = 0.
REQ-025 A valid tag travels with each sample through P1..P3; fir_valid is the P3 tag.
REQ-026 flush clears delay line, warm-up counter and all valid tags in one edge; coefficients are kept.
REQ-027 flush and data_valid in the same cycle: flush wins and the sample is dropped.
REQ-028 flush and coef_we in the same cycle: both take effect.
REQ-029 Gaps in data_valid do not disturb in-flight results; tags drain normally.

Reset
REQ-030 RST_N low asynchronously clears delay line, coefficients, pipeline registers, tags, warm-up counter, fir_valid=0 and fir_d=0.
REQ-031 Reset mid-stream aborts all in-flight results; no fir_valid is produced for samples accepted before reset.
REQ-032 After RST_N deasserts, the first edge accepts data_valid and coef_we normally.

Configuration
REQ-033 With macro FIR_PIPE_ROUND_EN defined, P3 adds 2^15 (round half up) before dropping 16 LSBs and before saturation.
REQ-034 With FIR_PIPE_ROUND_EN undefined, P3 truncates (floor) with no rounding adder; all other behaviour is identical.

Verification
REQ-035 Impulse: coef[0]=0x10000 (others 0), 32 samples of 0x0100 -> exactly one fir_valid pulse per sample from the 32nd onward, each fir_d=0x0100, 4 cycles after its sample.
REQ-036 Warm-up/latency: 31 samples -> fir_valid stays 0; the 32nd sample in cycle n -> fir_valid=1 in cycle n+4.
REQ-037 Saturation: all coef=0x10000 and 32 samples of 0x7FFF -> fir_d=0x7FFF; 32 samples of 0x8000 -> fir_d=0x8000.
REQ-038 Rounding: coef[0]=0x08000 and input 0x0001 -> fir_d=0x0001 with FIR_PIPE_ROUND_EN, 0x0000 without.
REQ-039 Flush mid-stream: assert flush together with data_valid after 40 samples -> that sample is dropped, in-flight results are killed, and no fir_valid occurs until 32 new samples; coefficients are unchanged.
REQ-040 Async reset: pull RST_N low for 1 cycle with 3 results in flight -> outputs go 0 immediately, no late fir_valid, coefficients read back as 0 in the impulse response.
